// File: rtl/fp_pkg.sv
// Shared FP32 field constants and accumulator state encoding.
// Used by fp_accum_seq and fp_adder.
package fp_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] QNAN        = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational FP32 adder, truncating, normal operands only.
// Zero operands are not special-cased; callers filter them.
module fp_adder
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] big;
  logic [31:0] sml;
  logic [7:0]  sh;
  logic [7:0]  e;
  logic [23:0] ms;
  logic [23:0] m;
  logic [24:0] sum;

  always_comb begin
    big = a;
    sml = b;
    if (b[EXP_MSB:0] > a[EXP_MSB:0]) begin
      big = b;
      sml = a;
    end
    sh = big[EXP_MSB:EXP_LSB] - sml[EXP_MSB:EXP_LSB];
    ms = (sh > 8'd23) ? 24'd0 : ({1'b1, sml[MAN_MSB:0]} >> sh);
    if (big[SIGN_BIT] == sml[SIGN_BIT])
      sum = {2'b01, big[MAN_MSB:0]} + {1'b0, ms};
    else
      sum = {2'b01, big[MAN_MSB:0]} - {1'b0, ms};
    e = big[EXP_MSB:EXP_LSB];
    m = sum[23:0];
    if (sum[24]) begin
      m = sum[24:1];
      e = e + 8'd1;
    end
    // renormalise after cancellation
    for (int i = 0; i < 24; i++) begin
      if (!m[23] && m != 24'd0) begin
        m = m << 1;
        e = e - 8'd1;
      end
    end
    result = (m == 24'd0) ? 32'd0 : {big[SIGN_BIT], e, m[MAN_MSB:0]};
  end
endmodule

// File: rtl/fp_accum_seq.sv
// Sequential FP32 accumulator driving an external fp_adder.
// Define FP_ACCUM_SPECIAL_EN to flag exponent-FF elements and freeze acc at QNAN.
module fp_accum_seq
  import fp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  output logic [XLEN-1:0]  add_a,
  output logic [XLEN-1:0]  add_b,
  input  logic [XLEN-1:0]  add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             busy,
  output logic             exc
);
  state_t           state_q, state_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             exc_q, exc_d;
  logic             hs;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign exc       = exc_q;
  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign hs        = in_valid & in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          acc_d   = '0;
          exc_d   = 1'b0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (hs) begin
          cnt_d = cnt_inc;
          // adder cannot take zero operands: skip or bypass
          if (in_data[XLEN-2:0] == '0)
            acc_d = acc_q;
          else if (acc_q[XLEN-2:0] == '0)
            acc_d = in_data;
          else
            acc_d = add_result;
`ifdef FP_ACCUM_SPECIAL_EN
          if (exc_q || in_data[EXP_MSB:EXP_LSB] == EXP_SPECIAL) begin
            acc_d = QNAN;
            exc_d = 1'b1;
          end
`endif
          if (cnt_inc == len_q)
            state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      exc_q   <= exc_d;
    end
  end
endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq wired to fp_adder.
// Directed sums with hand-computed FP32 results.
module tb_fp_accum_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        exc;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fp_accum_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .exc(exc)
  );

  fp_adder u_add (.a(add_a), .b(add_b), .result(add_result));

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got %h expected none", out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("sum", out_data, e[31:0]);
        chk("exc", {31'd0, exc}, {31'd0, e[32]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sum(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int b;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    b = 0;
    while (!in_ready && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    tick();

    exp_q.push_back({1'b0, 32'h40600000});
    start_sum(8'd3);
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    send(32'h3F000000, 0);
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    wait_idle();

    exp_q.push_back({1'b0, 32'h00000000});
    start_sum(8'd0);
    chk("t2_latency", {31'd0, out_valid}, 32'd1);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    wait_idle();

    exp_q.push_back({1'b0, 32'h40000000});
    start_sum(8'd2);
    send(32'h00000000, 0);
    send(32'h40000000, 1);
    wait_idle();

    out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h40ECCCCC});
    start_sum(8'd2);
    send(32'h404CCCCC, 2);
    send(32'h40866666, 3);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data", out_data, 32'h40ECCCCC);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      start = (i == 2);
      len   = 8'd3;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_back_idle", {31'd0, busy}, 32'd0);

    start_sum(8'd4);
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 32'hBF000000});
    start_sum(8'd1);
    send(32'hBF000000, 0);
    wait_idle();

`ifdef FP_ACCUM_SPECIAL_EN
    exp_q.push_back({1'b1, 32'h7FC00000});
`else
    exp_q.push_back({1'b0, 32'h7F800000});
`endif
    start_sum(8'd2);
    send(32'h7F800000, 0);
    send(32'h3F800000, 0);
    wait_idle();

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
